// File: rtl/xbf_pkg.sv
// Shared definitions for the beamformer S2MM return path: widths, keep
// patterns, packer states and the beat record stored in the FIFO.
package xbf_pkg;

  localparam int SAMPLE_W = 64;
  localparam int AXIS_W   = 128;
  localparam int KEEP_W   = AXIS_W / 8;
  localparam int BEAT_W   = AXIS_W + KEEP_W + 1;

  localparam logic [KEEP_W-1:0] KEEP_FULL = 16'hFFFF;
  localparam logic [KEEP_W-1:0] KEEP_HALF = 16'h00FF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  typedef struct packed {
    logic              last;
    logic [KEEP_W-1:0] keep;
    logic [AXIS_W-1:0] data;
  } beat_t;

  // Complex sum packed as one sample: real part in the low half.
  function automatic logic [SAMPLE_W-1:0] make_sample(input logic [31:0] re,
                                                      input logic [31:0] im);
    return {im, re};
  endfunction

endpackage

// File: rtl/xbf_s2mm_fifo.sv
// Beat FIFO between the packer and the AXI4-Stream master. The output
// register is part of the FIFO and counts towards its FIFO_DEPTH capacity,
// so "full" means FIFO_DEPTH beats are held in total.
module xbf_s2mm_fifo
  import xbf_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic  clk,
  input  logic  rstn,
  input  logic  wr_en,
  input  beat_t wr_data,
  output logic  full,
  output logic  empty,
  output beat_t rd_data,
  output logic  rd_valid,
  input  logic  rd_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  beat_t         mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   mem_count;
  logic [AW:0]   occupancy;
  logic          load;

  // The output register refills whenever it is empty or being retired.
  assign load      = (!rd_valid || rd_ready) && (mem_count != '0);
  assign occupancy = mem_count + {{AW{1'b0}}, rd_valid};
  assign full      = (occupancy == DEPTH_CNT);
  assign empty     = (occupancy == '0);

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointer and fill-level bookkeeping for the storage array.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (load)  rd_ptr <= rd_ptr + PTR_ONE;
      if (wr_en && !load)      mem_count <= mem_count + CNT_ONE;
      else if (!wr_en && load) mem_count <= mem_count - CNT_ONE;
    end
  end

  // Registered read side: holds the beat steady until it is accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (load) begin
      rd_valid <= 1'b1;
      rd_data  <= mem[rd_ptr];
    end else if (rd_valid && rd_ready) begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/xbf_s2mm_packer.sv
// Beamformer return path: packs pairs of 64-bit complex sums into 128-bit
// AXI4-Stream beats for the DMA S2MM channel, frames them with tlast and
// buffers them in a FIFO that drops (and flags) rather than stalls.
// Optional build macro XBF_S2MM_HDR_EN prepends a header beat per frame.
module xbf_s2mm_packer
  import xbf_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              sum_valid,
  input  logic [31:0]       sum_r,
  input  logic [31:0]       sum_i,
  output logic [AXIS_W-1:0] M_AXIS_S2MM_0_tdata,
  output logic [KEEP_W-1:0] M_AXIS_S2MM_0_tkeep,
  output logic              M_AXIS_S2MM_0_tlast,
  output logic              M_AXIS_S2MM_0_tvalid,
  input  logic              M_AXIS_S2MM_0_tready,
  output logic              busy,
  output logic              overflow,
  output logic [LEN_W-1:0]  sample_cnt
);

  state_t              state;
  state_t              next_state;
  logic [LEN_W-1:0]    len_q;
  logic [SAMPLE_W-1:0] stage_lo;
  logic [SAMPLE_W-1:0] sample_word;
  logic                is_last;
  logic                arm;
  logic                take;
  logic                beat_gen;
  beat_t               beat_next;
  logic                push_valid;
  beat_t               push_beat;
  logic                push_ok;
  logic                drop;
  logic                fifo_full;
  logic                fifo_empty;
  beat_t               out_beat;
  logic                out_valid;
`ifdef XBF_S2MM_HDR_EN
  logic [15:0]         frame_num;
`endif

  assign sample_word = make_sample(sum_r, sum_i);
  assign is_last     = ((sample_cnt + LEN_W'(1)) == len_q);

  // Packer state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  // Next state plus the beat completed by this cycle's sample or start.
  always_comb begin
    next_state = state;
    arm        = 1'b0;
    take       = 1'b0;
    beat_gen   = 1'b0;
    beat_next  = '0;
    case (state)
      IDLE: begin
        if (start && (frame_len != '0)) begin
          arm        = 1'b1;
          next_state = LOW;
`ifdef XBF_S2MM_HDR_EN
          beat_gen             = 1'b1;
          beat_next.data[15:0]  = 16'(frame_len);
          beat_next.data[31:16] = frame_num;
          beat_next.keep       = KEEP_FULL;
          beat_next.last       = 1'b0;
`endif
        end
      end
      LOW: begin
        if (sum_valid) begin
          take = 1'b1;
          if (is_last) begin
            beat_gen       = 1'b1;
            beat_next.data = {{SAMPLE_W{1'b0}}, sample_word};
            beat_next.keep = KEEP_HALF;
            beat_next.last = 1'b1;
            next_state     = IDLE;
          end else begin
            next_state = HIGH;
          end
        end
      end
      HIGH: begin
        if (sum_valid) begin
          take           = 1'b1;
          beat_gen       = 1'b1;
          beat_next.data = {sample_word, stage_lo};
          beat_next.keep = KEEP_FULL;
          beat_next.last = is_last;
          next_state     = is_last ? IDLE : LOW;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Frame length latch, low-half staging and per-frame sample counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_q      <= '0;
      stage_lo   <= '0;
      sample_cnt <= '0;
    end else begin
      if (arm) begin
        len_q      <= frame_len;
        sample_cnt <= '0;
      end else if (take) begin
        sample_cnt <= sample_cnt + LEN_W'(1);
      end
      if (take) stage_lo <= sample_word;
    end
  end

  // One-cycle push slot: a beat is offered to the FIFO the cycle after it completes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      push_valid <= 1'b0;
      push_beat  <= '0;
    end else begin
      push_valid <= beat_gen;
      if (beat_gen) push_beat <= beat_next;
    end
  end

  // A retiring output beat frees a slot in the same cycle, so a full FIFO can still accept.
  assign push_ok = push_valid && (!fifo_full || (out_valid && M_AXIS_S2MM_0_tready));
  assign drop    = push_valid && !push_ok;

  // Sticky overflow; a lost beat outranks a simultaneous clearing start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                          overflow <= 1'b0;
    else if (drop)                      overflow <= 1'b1;
    else if (start && (state == IDLE))  overflow <= 1'b0;
  end

`ifdef XBF_S2MM_HDR_EN
  // Frame number carried in the header, advanced per armed frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    frame_num <= '0;
    else if (arm) frame_num <= frame_num + 16'd1;
  end
`endif

  xbf_s2mm_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (push_ok),
    .wr_data  (push_beat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .rd_data  (out_beat),
    .rd_valid (out_valid),
    .rd_ready (M_AXIS_S2MM_0_tready)
  );

  assign M_AXIS_S2MM_0_tdata  = out_beat.data;
  assign M_AXIS_S2MM_0_tkeep  = out_beat.keep;
  assign M_AXIS_S2MM_0_tlast  = out_beat.last;
  assign M_AXIS_S2MM_0_tvalid = out_valid;

  assign busy = (state != IDLE) || push_valid || !fifo_empty || out_valid;

endmodule
